// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream as big-endian words into instruction memory and holds the core until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module imem_loader #(
   parameter int AW = 10,
   parameter int DEPTH = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_req,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   input  logic [31:0]   fetch_addr,
   output logic [31:0]   fetch_instr,
   output logic          core_hold,
   output logic          load_done,
   output logic          load_err,
   output logic [AW:0]   words_loaded
);
   typedef enum logic [2:0] {
      IDLE, HDR0, HDR1, DATA, RUN, ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
      , CSUM
`endif
   } state_t;
   state_t state;
   logic [31:0] mem [DEPTH];
   logic [7:0] hdr_hi;
   logic [AW:0] n_words;
   logic [23:0] asm_word;
   logic [1:0] lane;
   logic [AW-1:0] wr_ptr;
   logic [15:0] n_hdr;
   logic xfer, wr_en, last;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum;
`endif
   // a load_req on the same edge as a byte wins; the byte is dropped
   assign xfer = rx_valid & rx_ready & ~load_req;
   assign n_hdr = {hdr_hi, rx_data};
   assign wr_en = xfer && state == DATA && lane == 2'd3;
   assign last = (state == HDR1 && n_hdr == 16'd0) || (wr_en && words_loaded + (AW+1)'(1) == n_words);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         rx_ready <= 1'b0;
         core_hold <= 1'b1;
         load_done <= 1'b0;
         load_err <= 1'b0;
         words_loaded <= '0;
         lane <= '0;
         wr_ptr <= '0;
         hdr_hi <= '0;
         n_words <= '0;
         asm_word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum <= '0;
`endif
      end else begin
         load_done <= 1'b0;
         if (load_req) begin
            state <= HDR0;
            rx_ready <= 1'b1;
            core_hold <= 1'b1;
            load_err <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
         end else if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
            if (last)
               state <= CSUM;
`else
            if (last) begin
               state <= RUN;
               rx_ready <= 1'b0;
               core_hold <= 1'b0;
               load_done <= 1'b1;
            end
`endif
            case (state)
               HDR0: begin
                  hdr_hi <= rx_data;
                  state <= HDR1;
               end
               HDR1: begin
                  if (32'(n_hdr) > 32'(DEPTH)) begin
                     state <= ERR;
                     rx_ready <= 1'b0;
                     load_err <= 1'b1;
                  end else if (n_hdr != 16'd0) begin
                     state <= DATA;
                     n_words <= n_hdr[AW:0];
                     wr_ptr <= '0;
                     lane <= '0;
                  end
               end
               DATA: begin
                  lane <= lane + 2'd1;
                  asm_word <= {asm_word[15:0], rx_data};
                  if (lane == 2'd3) begin
                     wr_ptr <= wr_ptr + AW'(1);
                     words_loaded <= words_loaded + (AW+1)'(1);
                  end
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               CSUM: begin
                  rx_ready <= 1'b0;
                  if (rx_data == csum) begin
                     state <= RUN;
                     core_hold <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     state <= ERR;
                     load_err <= 1'b1;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end
   // memory is deliberately outside reset so a reset keeps loaded code
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= {asm_word, rx_data};
   assign fetch_instr = (fetch_addr < 32'(DEPTH) && !core_hold) ? mem[fetch_addr[AW-1:0]] : '0;
endmodule
